// File: rtl/template_match_argmax.sv
// ============================================================================
//  Module   : template_match_argmax
//  Purpose  : Streaming dot-product template matcher. Reports the index and
//             score of the best-scoring template through a valid/ready result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module template_match_argmax #(
    parameter int DATA_W      = 8,
    parameter int N_PIXELS    = 64,
    parameter int N_TEMPLATES = 10,
    localparam int IDX_W      = $clog2(N_TEMPLATES),
    localparam int ACC_W      = 2*DATA_W + $clog2(N_PIXELS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] current,
    input  logic [DATA_W-1:0] reference,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  best_index,
    output logic [ACC_W-1:0]  best_score
);

    localparam int PIX_W  = $clog2(N_PIXELS);
    localparam int PROD_W = 2*DATA_W;
    localparam logic [PIX_W-1:0] c_PIX_LAST = PIX_W'(N_PIXELS - 1);
    localparam logic [IDX_W-1:0] c_TPL_LAST = IDX_W'(N_TEMPLATES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [PIX_W-1:0]  r_pix_cnt;
    logic [IDX_W-1:0]  r_tpl_cnt;
    logic              r_s1_valid;
    logic              r_s1_last;
    logic [IDX_W-1:0]  r_s1_tpl;
    logic [PROD_W-1:0] r_s1_prod;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_max;
    logic [IDX_W-1:0]  r_idx;
    logic              r_max_valid;

    logic              w_accept;
    logic              w_last_pix;
    logic              w_last_beat;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_score;

    assign in_ready    = (r_state == S_RUN);
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign best_index  = r_idx;
    assign best_score  = r_max;

    assign w_accept    = in_valid && in_ready;
    assign w_last_pix  = (r_pix_cnt == c_PIX_LAST);
    assign w_last_beat = w_last_pix && (r_tpl_cnt == c_TPL_LAST);
    assign w_prod      = PROD_W'(current) * PROD_W'(reference);
    assign w_score     = r_acc + ACC_W'(r_s1_prod);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FLUSH leaves only once S1 is empty, i.e. the last compare has landed
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_accept && w_last_beat) w_next = S_FLUSH;
            S_FLUSH: if (!r_s1_valid) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pix_cnt   <= '0;
            r_tpl_cnt   <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_tpl    <= '0;
            r_s1_prod   <= '0;
            r_acc       <= '0;
            r_max       <= '0;
            r_idx       <= '0;
            r_max_valid <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_pix_cnt   <= '0;
                r_tpl_cnt   <= '0;
                r_acc       <= '0;
                r_max_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_last_pix) begin
                    r_pix_cnt <= '0;
                    r_tpl_cnt <= r_tpl_cnt + 1'b1;
                end else begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
            end

            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod <= w_prod;
                r_s1_last <= w_last_pix;
                r_s1_tpl  <= r_tpl_cnt;
            end

            // Strict '>' keeps the lower index on ties
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_acc       <= '0;
                    r_max_valid <= 1'b1;
                    if (!r_max_valid || (w_score > r_max)) begin
                        r_max <= w_score;
                        r_idx <= r_s1_tpl;
                    end
                end else begin
                    r_acc <= w_score;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_template_match_argmax.sv
// ============================================================================
//  Module   : tb_template_match_argmax
//  Purpose  : Directed self-checking bench for template_match_argmax.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_template_match_argmax;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Small instance: 4 pixels x 3 templates
    logic        start_s = 0, in_valid_s = 0, out_ready_s = 0;
    logic [7:0]  cur_s = 0, ref_s = 0;
    logic        in_ready_s, busy_s, out_valid_s;
    logic [1:0]  idx_s;
    logic [17:0] score_s;

    // Large instance: 64 pixels x 10 templates
    logic        start_l = 0, in_valid_l = 0, out_ready_l = 0;
    logic [7:0]  cur_l = 0, ref_l = 0;
    logic        in_ready_l, busy_l, out_valid_l;
    logic [3:0]  idx_l;
    logic [21:0] score_l;

    template_match_argmax #(.DATA_W(8), .N_PIXELS(4), .N_TEMPLATES(3)) dut_s (
        .clock(clock), .reset(reset), .start(start_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .current(cur_s), .reference(ref_s), .busy(busy_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .best_index(idx_s),
        .best_score(score_s)
    );

    template_match_argmax #(.DATA_W(8), .N_PIXELS(64), .N_TEMPLATES(10)) dut_l (
        .clock(clock), .reset(reset), .start(start_l), .in_valid(in_valid_l),
        .in_ready(in_ready_l), .current(cur_l), .reference(ref_l), .busy(busy_l),
        .out_valid(out_valid_l), .out_ready(out_ready_l), .best_index(idx_l),
        .best_score(score_l)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] img_s [4];
    logic [7:0] tpl_s [3][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_small();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        chk("run_busy", 32'(busy_s), 32'd1);
        chk("run_in_ready", 32'(in_ready_s), 32'd1);
    endtask

    // Streams n_beats beats of img_s/tpl_s; optionally pulses start mid-run
    task automatic feed_small(input bit bubbles, input bit poke_start, input int n_beats);
        int b;
        b = 0;
        for (int t = 0; t < 3; t++) begin
            for (int p = 0; p < 4; p++) begin
                if (b < n_beats) begin
                    if (bubbles) begin
                        for (int k = 0; k < 8 && $urandom_range(1, 0) == 1; k++) begin
                            in_valid_s = 1'b0;
                            tick();
                        end
                    end
                    in_valid_s = 1'b1;
                    cur_s      = img_s[p];
                    ref_s      = tpl_s[t][p];
                    start_s    = poke_start && (b == 5);
                    tick();
                    b++;
                end
            end
        end
        in_valid_s = 1'b0;
        start_s    = 1'b0;
    endtask

    // Called right after the final beat edge: checks latency, hold and release
    task automatic result_small(input string tag, input int exp_idx, input int exp_score,
                                input bit hold);
        chk({tag, "_flush_ready"}, 32'(in_ready_s), 32'd0);
        chk({tag, "_valid_k1"}, 32'(out_valid_s), 32'd0);
        tick();
        chk({tag, "_valid_k2"}, 32'(out_valid_s), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid_s), 32'd1);
        chk({tag, "_index"}, 32'(idx_s), 32'(exp_idx));
        chk({tag, "_score"}, 32'(score_s), 32'(exp_score));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                chk({tag, "_hold_valid"}, 32'(out_valid_s), 32'd1);
                chk({tag, "_hold_index"}, 32'(idx_s), 32'(exp_idx));
                chk({tag, "_hold_score"}, 32'(score_s), 32'(exp_score));
            end
        end
        out_ready_s = 1'b1;
        tick();
        out_ready_s = 1'b0;
        chk({tag, "_released"}, 32'(out_valid_s), 32'd0);
        chk({tag, "_idle"}, 32'(busy_s), 32'd0);
    endtask

    task automatic model_small(output int ei, output int es);
        int s;
        ei = 0;
        es = -1;
        for (int t = 0; t < 3; t++) begin
            s = 0;
            for (int p = 0; p < 4; p++) s += int'(img_s[p]) * int'(tpl_s[t][p]);
            if (s > es) begin
                es = s;
                ei = t;
            end
        end
    endtask

    task automatic load_small(input int c, input int t0, input int t1, input int t2);
        for (int p = 0; p < 4; p++) begin
            img_s[p]    = 8'(c);
            tpl_s[0][p] = 8'(t0);
            tpl_s[1][p] = 8'(t1);
            tpl_s[2][p] = 8'(t2);
        end
    endtask

    initial begin
        int ei, es;

        // Reset then idle with start low
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("idle_in_ready", 32'(in_ready_s), 32'd0);
        chk("idle_busy", 32'(busy_s), 32'd0);
        chk("idle_out_valid", 32'(out_valid_s), 32'd0);
        chk("idle_index", 32'(idx_s), 32'd0);
        chk("idle_score", 32'(score_s), 32'd0);
        chk("idle_l_busy", 32'(busy_l), 32'd0);
        chk("idle_l_score", 32'(score_l), 32'd0);

        // Scores 4, 8, 1 -> template 1 wins with 8
        load_small(1, 1, 2, 0);
        tpl_s[2][0] = 8'd1;
        start_small();
        feed_small(1'b0, 1'b0, 12);
        result_small("basic", 1, 8, 1'b0);

        // Tie between templates 0 and 2 at 255*255*4 keeps index 0
        load_small(255, 255, 0, 255);
        start_small();
        feed_small(1'b0, 1'b0, 12);
        result_small("tie", 0, 260100, 1'b0);

        // All-zero scores
        load_small(7, 0, 0, 0);
        start_small();
        feed_small(1'b0, 1'b0, 12);
        result_small("zero", 0, 0, 1'b0);

        // Random data with bubbles against the model, first run held 5 cycles
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) begin
                img_s[p] = 8'($urandom_range(255, 0));
                for (int t = 0; t < 3; t++) tpl_s[t][p] = 8'($urandom_range(255, 0));
            end
            model_small(ei, es);
            start_small();
            feed_small(1'b1, 1'b0, 12);
            result_small("random", ei, es, r == 0);
        end

        // Reset mid-run at tpl_cnt=1 with heavy stale data, then a fresh run
        load_small(255, 255, 255, 255);
        start_small();
        feed_small(1'b0, 1'b0, 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy_s), 32'd0);
        chk("rst_in_ready", 32'(in_ready_s), 32'd0);
        chk("rst_score", 32'(score_s), 32'd0);
        load_small(2, 1, 0, 5);
        start_small();
        feed_small(1'b0, 1'b1, 12);
        result_small("rst_fresh", 2, 40, 1'b0);

        // Max operands on the 64-pixel instance: every template scores 4161600
        start_l = 1'b1;
        tick();
        start_l = 1'b0;
        cur_l = 8'd255;
        ref_l = 8'd255;
        in_valid_l = 1'b1;
        repeat (640) tick();
        in_valid_l = 1'b0;
        chk("max_flush_ready", 32'(in_ready_l), 32'd0);
        tick();
        chk("max_valid_k2", 32'(out_valid_l), 32'd0);
        tick();
        chk("max_valid", 32'(out_valid_l), 32'd1);
        chk("max_index", 32'(idx_l), 32'd0);
        chk("max_score", 32'(score_l), 32'd4161600);
        out_ready_l = 1'b1;
        tick();
        out_ready_l = 1'b0;
        chk("max_released", 32'(out_valid_l), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
